// File: rtl/alu32_flag_reg_pkg.sv
// Shared types and helpers for the ALU flag/status register.
package alu32_flag_reg_pkg;

   localparam int unsigned OP_W   = 3;
   localparam int unsigned CC_W   = 4;
   localparam int unsigned FLAG_W = 4;

   // Flag vector, bit positions N=3, Z=2, C=1, V=0
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   // Condition codes
   typedef enum logic [CC_W-1:0] {
      CC_EQ = 4'h0,
      CC_NE = 4'h1,
      CC_CS = 4'h2,
      CC_CC = 4'h3,
      CC_MI = 4'h4,
      CC_PL = 4'h5,
      CC_VS = 4'h6,
      CC_VC = 4'h7,
      CC_HI = 4'h8,
      CC_LS = 4'h9,
      CC_GE = 4'hA,
      CC_LT = 4'hB,
      CC_GT = 4'hC,
      CC_LE = 4'hD,
      CC_AL = 4'hE,
      CC_NV = 4'hF
   } cond_e;

   // Arithmetic opcodes are the ones allowed to update C and V
   function automatic logic is_arith(input logic [OP_W-1:0] op);
      return op[2:1] == 2'b11;
   endfunction

endpackage

// File: rtl/alu32_flag_reg_if.sv
// Flag capture, sticky status and condition-query bus.
interface alu32_flag_reg_if #(
   parameter int unsigned CNT_W = 8
);
   logic             flags_valid;
   logic [2:0]       op;
   logic             c_in;
   logic             n_in;
   logic             z_in;
   logic             v_in;
   logic             clr_sticky;
   logic             cond_req;
   logic [3:0]       cond;
   logic [3:0]       flags_q;
   logic             c_sticky;
   logic             v_sticky;
   logic [CNT_W-1:0] ovf_cnt;
   logic             cond_valid;
   logic             cond_true;

   modport master (
      output flags_valid, op, c_in, n_in, z_in, v_in, clr_sticky, cond_req, cond,
      input  flags_q, c_sticky, v_sticky, ovf_cnt, cond_valid, cond_true
   );

   modport slave (
      input  flags_valid, op, c_in, n_in, z_in, v_in, clr_sticky, cond_req, cond,
      output flags_q, c_sticky, v_sticky, ovf_cnt, cond_valid, cond_true
   );
endinterface

// File: rtl/alu32_flag_reg_cond_eval.sv
// Combinational condition-code evaluator over a {N,Z,C,V} flag vector.
module alu32_flag_reg_cond_eval
   import alu32_flag_reg_pkg::*;
(
   input  logic [CC_W-1:0]   cond_i,
   input  flags_t            flags_i,
   output logic              true_o
);

   // Decode the condition against the supplied flags
   always_comb begin
      true_o = 1'b0;
      unique case (cond_e'(cond_i))
         CC_EQ: true_o = flags_i.z;
         CC_NE: true_o = ~flags_i.z;
         CC_CS: true_o = flags_i.c;
         CC_CC: true_o = ~flags_i.c;
         CC_MI: true_o = flags_i.n;
         CC_PL: true_o = ~flags_i.n;
         CC_VS: true_o = flags_i.v;
         CC_VC: true_o = ~flags_i.v;
         CC_HI: true_o = flags_i.c & ~flags_i.z;
         CC_LS: true_o = ~flags_i.c | flags_i.z;
         CC_GE: true_o = (flags_i.n == flags_i.v);
         CC_LT: true_o = (flags_i.n != flags_i.v);
         CC_GT: true_o = ~flags_i.z & (flags_i.n == flags_i.v);
         CC_LE: true_o = flags_i.z | (flags_i.n != flags_i.v);
         CC_AL: true_o = 1'b1;
         CC_NV: true_o = 1'b0;
         default: true_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu32_flag_reg.sv
// Architectural flag register with sticky C/V, saturating overflow counter
// and a registered condition-code query port.
module alu32_flag_reg
   import alu32_flag_reg_pkg::*;
#(
   parameter int unsigned CNT_W = 8
)(
   input  logic              clk,
   input  logic              reset,
   alu32_flag_reg_if.slave   bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   flags_t           flag_q,       flag_d;
   logic             c_sticky_q,   c_sticky_d;
   logic             v_sticky_q,   v_sticky_d;
   logic [CNT_W-1:0] ovf_cnt_q,    ovf_cnt_d;
   logic             cond_valid_q, cond_valid_d;
   logic             cond_true_q,  cond_true_d;

   logic arith_cap;
   logic cond_hit;

   assign arith_cap = bus.flags_valid & is_arith(bus.op);

   // Next-state flags: N/Z on every capture, C/V only on arithmetic captures
   always_comb begin
      flag_d = flag_q;
      if (bus.flags_valid) begin
         flag_d.n = bus.n_in;
         flag_d.z = bus.z_in;
         if (is_arith(bus.op)) begin
            flag_d.c = bus.c_in;
            flag_d.v = bus.v_in;
         end
      end
   end

   // Sticky bits and overflow counter; a clear overrides a coincident capture
   always_comb begin
      c_sticky_d = c_sticky_q | (arith_cap & bus.c_in);
      v_sticky_d = v_sticky_q | (arith_cap & bus.v_in);
      ovf_cnt_d  = ovf_cnt_q;
      if (arith_cap && bus.v_in && (ovf_cnt_q != CNT_MAX)) begin
         ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
      end
      if (bus.clr_sticky) begin
         c_sticky_d = 1'b0;
         v_sticky_d = 1'b0;
         ovf_cnt_d  = '0;
      end
   end

   // Queries see the bypassed next-state flags
   alu32_flag_reg_cond_eval u_cond_eval (
      .cond_i  (bus.cond),
      .flags_i (flag_d),
      .true_o  (cond_hit)
   );

   assign cond_valid_d = bus.cond_req;
   assign cond_true_d  = bus.cond_req & cond_hit;

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         flag_q       <= '0;
         c_sticky_q   <= 1'b0;
         v_sticky_q   <= 1'b0;
         ovf_cnt_q    <= '0;
         cond_valid_q <= 1'b0;
         cond_true_q  <= 1'b0;
      end else begin
         flag_q       <= flag_d;
         c_sticky_q   <= c_sticky_d;
         v_sticky_q   <= v_sticky_d;
         ovf_cnt_q    <= ovf_cnt_d;
         cond_valid_q <= cond_valid_d;
         cond_true_q  <= cond_true_d;
      end
   end

   assign bus.flags_q    = flag_q;
   assign bus.c_sticky   = c_sticky_q;
   assign bus.v_sticky   = v_sticky_q;
   assign bus.ovf_cnt    = ovf_cnt_q;
   assign bus.cond_valid = cond_valid_q;
   assign bus.cond_true  = cond_true_q;

endmodule

// File: tb/tb_alu32_flag_reg.sv
// Directed self-checking bench for alu32_flag_reg (CNT_W=2).
module tb_alu32_flag_reg;

   localparam int unsigned CNT_W = 2;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   alu32_flag_reg_if #(.CNT_W(CNT_W)) bus ();

   alu32_flag_reg #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.flags_valid = 1'b0;
      bus.op          = 3'b000;
      bus.c_in        = 1'b0;
      bus.n_in        = 1'b0;
      bus.z_in        = 1'b0;
      bus.v_in        = 1'b0;
      bus.clr_sticky  = 1'b0;
      bus.cond_req    = 1'b0;
      bus.cond        = 4'h0;
   endtask

   task automatic cap(input logic [2:0] op, input logic n, input logic z,
                      input logic c, input logic v);
      bus.flags_valid = 1'b1;
      bus.op          = op;
      bus.n_in        = n;
      bus.z_in        = z;
      bus.c_in        = c;
      bus.v_in        = v;
   endtask

   task automatic query(input logic [3:0] cc);
      bus.cond_req = 1'b1;
      bus.cond     = cc;
   endtask

   // Advance one clock, sample 1 time unit after the edge, then clear inputs
   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic chk_resp(input string tag, input logic v, input logic t);
      chk({tag, "_valid"}, 32'(bus.cond_valid), 32'(v));
      chk({tag, "_true"},  32'(bus.cond_true),  32'(t));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      idle();
      reset = 1'b1;
      tick();
      tick();

      // Reset state
      chk("rst_flags",  32'(bus.flags_q),  32'h0);
      chk("rst_csticky", 32'(bus.c_sticky), 32'h0);
      chk("rst_vsticky", 32'(bus.v_sticky), 32'h0);
      chk("rst_cnt",    32'(bus.ovf_cnt),  32'h0);
      chk_resp("rst", 1'b0, 1'b0);
      reset = 1'b0;

      // Arithmetic capture
      cap(3'b110, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      chk("arith_flags",   32'(bus.flags_q),  32'h3);
      chk("arith_csticky", 32'(bus.c_sticky), 32'h1);
      chk("arith_vsticky", 32'(bus.v_sticky), 32'h1);
      chk("arith_cnt",     32'(bus.ovf_cnt),  32'h1);
      chk_resp("arith_noreq", 1'b0, 1'b0);

      // Logic op holds C/V
      cap(3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk("hold_flags", 32'(bus.flags_q), 32'hB);
      chk("hold_cnt",   32'(bus.ovf_cnt), 32'h1);

      // Bypass: capture and query in the same cycle
      cap(3'b111, 1'b0, 1'b1, 1'b0, 1'b0);
      query(4'h0);
      tick();
      chk_resp("byp_eq", 1'b1, 1'b1);
      chk("byp_flags", 32'(bus.flags_q), 32'h4);
      cap(3'b111, 1'b0, 1'b1, 1'b0, 1'b0);
      query(4'h1);
      tick();
      chk_resp("byp_ne", 1'b1, 1'b0);

      // Response deasserts without a request
      tick();
      chk_resp("no_req", 1'b0, 1'b0);

      // Signed compare: N=1, V=1
      cap(3'b110, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      chk("sc_flags", 32'(bus.flags_q), 32'h9);
      chk("sc_cnt",   32'(bus.ovf_cnt), 32'h2);
      query(4'hA);
      tick();
      chk_resp("ge", 1'b1, 1'b1);
      query(4'hB);
      tick();
      chk_resp("lt", 1'b1, 1'b0);

      // Z=1 via logic op; C=0, V=1 held
      cap(3'b010, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      chk("z_flags", 32'(bus.flags_q), 32'hD);
      query(4'hC); tick(); chk_resp("gt", 1'b1, 1'b0);
      query(4'hD); tick(); chk_resp("le", 1'b1, 1'b1);
      query(4'hE); tick(); chk_resp("al", 1'b1, 1'b1);
      query(4'hF); tick(); chk_resp("nv", 1'b1, 1'b0);
      query(4'h8); tick(); chk_resp("hi", 1'b1, 1'b0);
      query(4'h9); tick(); chk_resp("ls", 1'b1, 1'b1);
      query(4'h6); tick(); chk_resp("vs", 1'b1, 1'b1);
      query(4'h3); tick(); chk_resp("cc", 1'b1, 1'b1);

      // Clear alone
      bus.clr_sticky = 1'b1;
      tick();
      chk("clr_cnt",     32'(bus.ovf_cnt),  32'h0);
      chk("clr_vsticky", 32'(bus.v_sticky), 32'h0);
      chk("clr_csticky", 32'(bus.c_sticky), 32'h0);
      chk("clr_flags",   32'(bus.flags_q),  32'hD);

      // Saturation: four overflow captures
      for (int i = 0; i < 4; i++) begin
         cap(3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
         tick();
         chk($sformatf("sat_cnt%0d", i), 32'(bus.ovf_cnt), (i < 3) ? 32'(i + 1) : 32'h3);
      end
      chk("sat_vsticky", 32'(bus.v_sticky), 32'h1);
      chk("sat_csticky", 32'(bus.c_sticky), 32'h0);

      // Clear wins over a coincident overflow capture
      cap(3'b110, 1'b1, 1'b0, 1'b1, 1'b1);
      bus.clr_sticky = 1'b1;
      tick();
      chk("clrcap_cnt",     32'(bus.ovf_cnt),  32'h0);
      chk("clrcap_vsticky", 32'(bus.v_sticky), 32'h0);
      chk("clrcap_csticky", 32'(bus.c_sticky), 32'h0);
      chk("clrcap_flags",   32'(bus.flags_q),  32'hB);

      // Build up state, then reset alongside capture and query
      cap(3'b111, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      chk("pre_rst_cnt", 32'(bus.ovf_cnt), 32'h1);
      cap(3'b110, 1'b1, 1'b1, 1'b1, 1'b1);
      query(4'hE);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mrst_flags",   32'(bus.flags_q),  32'h0);
      chk("mrst_csticky", 32'(bus.c_sticky), 32'h0);
      chk("mrst_vsticky", 32'(bus.v_sticky), 32'h0);
      chk("mrst_cnt",     32'(bus.ovf_cnt),  32'h0);
      chk_resp("mrst", 1'b0, 1'b0);
      tick();
      chk_resp("post_rst", 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu32_flag_reg.md
# alu32_flag_reg

Architectural status register that sits directly downstream of the 32-bit ALU flag generator. It captures the C/N/Z/V flags produced for each valid ALU result and holds them between operations. It also maintains sticky carry/overflow bits and a saturating overflow-event counter, and answers 4-bit condition-code queries with a one-cycle registered response. It is the single source of flags for branch/conditional logic in the datapath.

## Interface
Parameters:
- CNT_W, 8, width of the overflow-event counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flags_valid  in  1  ALU result and flags valid this cycle
- op  in  3  ALU opcode of the flagged result
- c_in  in  1  carry flag from the ALU
- n_in  in  1  negative flag from the ALU
- z_in  in  1  zero flag from the ALU
- v_in  in  1  overflow flag from the ALU
- clr_sticky  in  1  clear sticky bits and the overflow counter
- cond_req  in  1  condition query strobe
- cond  in  4  condition code to evaluate
- flags_q  out  4  registered flags {N,Z,C,V}
- c_sticky  out  1  a carry has been captured since the last clear
- v_sticky  out  1  an overflow has been captured since the last clear
- ovf_cnt  out  CNT_W  saturating count of captured overflows
- cond_valid  out  1  response strobe, one cycle after cond_req
- cond_true  out  1  condition result, qualified by cond_valid

## Operation
- Arithmetic op: op[2:1]==2'b11.
- On flags_valid:
  - N and Z are always updated.
  - C and V are updated only for arithmetic ops.
  - For non-arithmetic ops, C and V hold their previous values.
- Sticky bits:
  - c_sticky is set on an arithmetic capture with c_in=1.
  - v_sticky is set on an arithmetic capture with v_in=1.
- ovf_cnt increments on each arithmetic capture with v_in=1 and saturates at 2^CNT_W-1 (no wrap).
- clr_sticky zeroes c_sticky, v_sticky and ovf_cnt. If clr_sticky coincides with a capture, the clear wins: all three are 0 next cycle. flags_q still updates normally.
- Condition codes:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F NV: 0
- Bypass: when cond_req and flags_valid are in the same cycle, the condition is evaluated against the next-state flags (after the C/V hold rule), not the stale flags_q.
- No backpressure. A cond_req is accepted every cycle, with one response per request.

## Timing
- Reset (clk edge with reset=1): flags_q=4'b0000, c_sticky=0, v_sticky=0, ovf_cnt=0, cond_valid=0, cond_true=0.
- A reset in the same cycle as flags_valid or cond_req discards both. No response is issued.
- Capture latency: flags_q, the sticky bits and ovf_cnt reflect a capture on the edge after flags_valid (1 cycle).
- Query latency: cond_valid/cond_true are asserted exactly one cycle after cond_req and are deasserted otherwise.
- cond_true is 0 whenever cond_valid=0.
- Back-to-back queries produce back-to-back responses, each on its own cycle.
- Saturation: at ovf_cnt = all-ones, a further overflow leaves it unchanged; v_sticky stays 1.

## Structure
- Shared header alu32_defs.vh holds:
  - opcode localparams and the ARITH predicate (op[2:1]==2'b11)
  - the 16 condition-code localparams
  - the flag bit positions (N=3, Z=2, C=1, V=0)
- One combinational sub-module, cond_eval (inputs cond[3:0] and {N,Z,C,V}; output true). It is instantiated once on the bypassed next-state flags.
- The rest is a single always block for the registers plus next-state assigns.

## Test plan
- Reset mid-stream: after captures, assert reset with flags_valid=1 and cond_req=1 → all outputs 0 next cycle, and cond_valid=0.
- Arithmetic capture: op=3'b110, c=1, n=0, z=0, v=1 → flags_q=4'b0011, c_sticky=1, v_sticky=1, ovf_cnt=1.
- C/V hold on a logic op: after the previous step, op=3'b000, n=1, z=0, c=0, v=0 → flags_q=4'b1011.
- Bypass: same cycle, op=3'b111, z=1, v=0, with cond=0 (EQ) → cond_valid=1, cond_true=1 next cycle. Repeat with cond=1 (NE) → cond_true=0.
- Signed compare: flags N=1, V=1 → GE true, LT false. Then Z=1 → GT false, LE true. AL → 1, NV → 0.
- Saturation and clear (CNT_W=2): four overflow captures → ovf_cnt=3. Then clr_sticky together with an overflow capture → ovf_cnt=0, v_sticky=0, flags_q V=1.
